dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-port 16-bit data memory (byte-addressed, combinational little-endian word read, word write committed on the falling clock edge). It sits between two requesters, port 0 (CPU load/store unit) and port 1 (DMA/debug loader), and the memory. Each cycle it selects at most one requester, drives the memory address, write-data and write-enable from that requester, and returns read data and an acknowledge. Arbitration is round-robin, with an optional bounded lock for back-to-back bursts.

---
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port 16-bit data memory.
// Port 0 is the CPU load/store unit and port 1 is the DMA/debug loader; bounded lock supports bursts.
module dmem_arbiter #(
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] MemAddress,
  output logic [15:0] MemWriteData,
  output logic        MemWrite,
  input  logic [15:0] MemReadData,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req/we/addr/wdata/lock until it samples ack=1 at a
  // rising edge; a req still high at that edge is a new back-to-back request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [3:0] MaxLock = 4'(MAX_LOCK);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    ack0         = 1'b0;
    ack1         = 1'b0;
    rdata0       = 16'h0000;
    rdata1       = 16'h0000;
    MemAddress   = 16'h0000;
    MemWriteData = 16'h0000;
    MemWrite     = 1'b0;
    busy         = 1'b0;

    if (!req0 && !req1) begin
      state_d = IDLE;
    end else if (req0 && !req1) begin
      state_d = G0;
    end else if (req1 && !req0) begin
      state_d = G1;
    end else if (state_q == G0 && lock0 && cnt_q < MaxLock) begin
      state_d = G0;
      cnt_d   = cnt_q + 4'd1;
    end else if (state_q == G1 && lock1 && cnt_q < MaxLock) begin
      state_d = G1;
      cnt_d   = cnt_q + 4'd1;
    end else begin
      state_d = last_q ? G0 : G1;
    end

    // An uncontested holder keeps its count; any port change or idle restarts it.
    if (state_d == IDLE || state_d != state_q) cnt_d = 4'd0;

    if (state_d == G0) last_d = 1'b0;
    else if (state_d == G1) last_d = 1'b1;

    case (state_q)
      G0: begin
        MemAddress   = addr0;
        MemWriteData = wdata0;
        MemWrite     = we0;
        ack0         = 1'b1;
        rdata0       = MemReadData;
        busy         = 1'b1;
      end
      G1: begin
        MemAddress   = addr1;
        MemWriteData = wdata1;
        MemWrite     = we1;
        ack1         = 1'b1;
        rdata1       = MemReadData;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed little-endian memory model
// that reads combinationally and commits word writes on the falling edge.
module tb_dmem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        lock0 = 1'b0, lock1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, MemWrite, busy;
  logic [15:0] rdata0, rdata1, MemAddress, MemWriteData, MemReadData;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:65535];
  logic [15:0] addr_p1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  dmem_arbiter #(.MAX_LOCK(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemReadData(MemReadData), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 Clock = ~Clock;

  // Memory model
  assign addr_p1     = MemAddress + 16'd1;
  assign MemReadData = {mem[addr_p1], mem[MemAddress]};
  always @(negedge Clock) begin
    if (MemWrite) begin
      mem[MemAddress] = MemWriteData[7:0];
      mem[addr_p1]    = MemWriteData[15:8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs change just after the falling edge, so they are stable across the
  // deciding rising edge and the following write edge.
  task automatic drive(input logic rst,
                       input logic r0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1);
    @(negedge Clock); #1;
    Reset = rst;
    req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic sample;
    @(posedge Clock); #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'hCD;
    mem[1] = 8'hAB;

    // Reset state
    sample; sample;
    check_eq("rst_state", dbg_state, 2'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_acks", {ack0, ack1}, 2'b00);
    check_eq("rst_memwrite", MemWrite, 1'b0);
    check_eq("rst_memaddr", MemAddress, 16'h0000);

    // First grant: port 0 read of 0x0000
    drive(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("rd0_ack0", ack0, 1'b1);
    check_eq("rd0_ack1", ack1, 1'b0);
    check_eq("rd0_rdata0", rdata0, 16'hABCD);
    check_eq("rd0_busy", busy, 1'b1);

    // Port 1 write, then port 0 and port 1 read it back
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0010, 16'h1234);
    sample;
    check_eq("wr1_ack1", ack1, 1'b1);
    check_eq("wr1_ack0", ack0, 1'b0);
    check_eq("wr1_memwrite", MemWrite, 1'b1);
    check_eq("wr1_memaddr", MemAddress, 16'h0010);
    check_eq("wr1_memwdata", MemWriteData, 16'h1234);
    check_eq("wr1_rdata0", rdata0, 16'h0000);
    drive(0, 1, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("rb0_ack0", ack0, 1'b1);
    check_eq("rb0_rdata0", rdata0, 16'h1234);
    check_eq("rb0_memwrite", MemWrite, 1'b0);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0010, 16'h0000);
    sample;
    check_eq("rb1_ack1", ack1, 1'b1);
    check_eq("rb1_rdata1", rdata1, 16'h1234);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("idle_state", dbg_state, 2'd0);
    check_eq("idle_busy", busy, 1'b0);

    // Both requesting, no lock: strict alternation starting with port 0
    drive(0, 1, 1, 0, 16'h0030, 16'h1111, 1, 1, 0, 16'h0040, 16'h2222);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd1);
    end
    for (int i = 0; i < 6; i++) begin
      sample;
      e = exp_q.pop_front();
      check_eq("alt_ack0", ack0, (e == 0) ? 1'b1 : 1'b0);
      check_eq("alt_ack1", ack1, (e == 1) ? 1'b1 : 1'b0);
      check_eq("alt_memaddr", MemAddress, (e == 0) ? 16'h0030 : 16'h0040);
    end
    drive(0, 1, 0, 0, 16'h0030, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("alt_rd30", rdata0, 16'h1111);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000);
    sample;
    check_eq("alt_rd40", rdata1, 16'h2222);

    // Lock: port 0 holds 4 contested grants, port 1 gets one, lock count restarts
    drive(0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("lock_first_ack0", ack0, 1'b1);
    drive(0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, 16'h0040, 16'h0000);
    exp_q = {};
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 7; i++) begin
      sample;
      e = exp_q.pop_front();
      check_eq("lock_ack0", ack0, (e == 0) ? 1'b1 : 1'b0);
      check_eq("lock_ack1", ack1, (e == 1) ? 1'b1 : 1'b0);
    end
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("lock_idle", dbg_state, 2'd0);

    // Reset while port 1 is granted and issuing a write
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0020, 16'h0000);
    sample;
    check_eq("rst_g1_ack1", ack1, 1'b1);
    check_eq("rst_g1_state", dbg_state, 2'd2);
    drive(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 1, 0, 16'h0020, 16'hBEEF);
    sample;
    check_eq("rst_mid_memwrite", MemWrite, 1'b0);
    check_eq("rst_mid_ack1", ack1, 1'b0);
    check_eq("rst_mid_state", dbg_state, 2'd0);
    drive(0, 1, 0, 0, 16'h0020, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("rst_mid_ack0", ack0, 1'b1);
    check_eq("rst_mid_word", rdata0, 16'h0000);

    // Write at the top of the address space; wrap is the memory's business
    drive(0, 1, 1, 0, 16'hFFFF, 16'h5AA5, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("top_memaddr", MemAddress, 16'hFFFF);
    check_eq("top_memwrite", MemWrite, 1'b1);
    check_eq("top_memwdata", MemWriteData, 16'h5AA5);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("top_memwrite_off", MemWrite, 1'b0);
    drive(0, 1, 0, 0, 16'hFFFF, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;
    check_eq("top_readback", rdata0, 16'h5AA5);
    drive(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000);
    sample;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
